// File: rtl/wb_debug_master.sv
// wb_debug_master: byte-stream driven Wishbone debug/loader master.
// A host sends 'W' + addr(4) + data(4) or 'R' + addr(4), LSB first. The block
// runs one single Wishbone cycle and answers with 'K' (write) or the four
// read-data bytes, LSB first.
// Build option: define WB_TIMEOUT_EN to add an ack watchdog of TIMEOUT_CYCLES
// bus cycles. When it expires, the cycle is abandoned and the single byte 'E'
// is returned.
//
// state | meaning
// IDLE  | waiting for a command byte; other bytes are ignored
// ADDR  | collecting four address bytes
// DATA  | collecting four write-data bytes ('W' only)
// BUS   | Wishbone cycle in flight; rx bytes are dropped
// RESP  | handing response bytes to the tx sink; rx bytes are dropped
module wb_debug_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_dat_i,
  input  logic        rx_vld_i,
  output logic [7:0]  tx_dat_o,
  output logic        tx_vld_o,
  input  logic        tx_rdy_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  state_t      state, state_nxt;
  logic        op_write;
  logic [1:0]  byte_cnt;
  logic [31:0] adr_q;
  logic [31:0] wdat_q;
  logic [31:0] rdat_q;
  logic        cyc_q;
  logic        we_q;
  logic        err_q;

  logic        cmd_ok;
  logic        byte_last;
  logic        tx_fire;
  logic        resp_last;
  logic        bus_done;
  logic        bus_tmo;
  logic [7:0]  tx_byte;

  assign cmd_ok    = (rx_dat_i == CMD_WR) || (rx_dat_i == CMD_RD);
  assign byte_last = (byte_cnt == 2'd3);
  assign tx_fire   = (state == RESP) && tx_rdy_i;
  assign resp_last = op_write || err_q || byte_last;
  assign bus_done  = cyc_q && wb_ack_i;

`ifdef WB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;

  // Watchdog: counts un-acked bus cycles; held at zero outside BUS.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      tmo_cnt <= '0;
    else if (state != BUS)
      tmo_cnt <= '0;
    else if (cyc_q && !wb_ack_i)
      tmo_cnt <= tmo_cnt + 16'd1;
  end

  // An ack in the expiry cycle takes priority over the timeout.
  assign bus_tmo = cyc_q && !wb_ack_i && (tmo_cnt == TMO_LAST);
`else
  // The limit only matters when the watchdog is built in.
  logic [15:0] unused_tmo;
  assign unused_tmo = 16'(TIMEOUT_CYCLES);
  assign bus_tmo    = 1'b0;
`endif

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rx_vld_i && cmd_ok) state_nxt = ADDR;
      ADDR: if (rx_vld_i && byte_last) state_nxt = op_write ? DATA : BUS;
      DATA: if (rx_vld_i && byte_last) state_nxt = BUS;
      BUS:  if (bus_done || bus_tmo) state_nxt = RESP;
      RESP: if (tx_fire && resp_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: byte collection, bus cycle control, read capture, response index.
  // Fields arrive LSB first, so shifting in from the top leaves byte k in [8k+7:8k].
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      op_write <= 1'b0;
      byte_cnt <= 2'd0;
      adr_q    <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_vld_i && cmd_ok) begin
            op_write <= (rx_dat_i == CMD_WR);
            byte_cnt <= 2'd0;
            err_q    <= 1'b0;
          end
        end
        ADDR: begin
          if (rx_vld_i) begin
            adr_q    <= {rx_dat_i, adr_q[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_last && !op_write)
              cyc_q <= 1'b1;
          end
        end
        DATA: begin
          if (rx_vld_i) begin
            wdat_q   <= {rx_dat_i, wdat_q[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_last) begin
              cyc_q <= 1'b1;
              we_q  <= 1'b1;
            end
          end
        end
        BUS: begin
          if (bus_done) begin
            if (!op_write)
              rdat_q <= wb_dat_i;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            byte_cnt <= 2'd0;
          end else if (bus_tmo) begin
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b1;
            byte_cnt <= 2'd0;
          end
        end
        RESP: begin
          if (tx_fire)
            byte_cnt <= byte_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Response byte select; zero outside RESP.
  always_comb begin
    tx_byte = 8'h00;
    if (state == RESP) begin
      if (err_q)
        tx_byte = RSP_ERR;
      else if (op_write)
        tx_byte = RSP_OK;
      else
        tx_byte = rdat_q[8*byte_cnt +: 8];
    end
  end

  assign tx_dat_o = tx_byte;
  assign tx_vld_o = (state == RESP);
  assign wb_adr_o = adr_q;
  assign wb_dat_o = wdat_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = 4'hF;
  assign wb_stb_o = cyc_q;
  assign wb_cyc_o = cyc_q;
  assign busy_o   = (state != IDLE);

endmodule
